// File: rtl/inst_fetch_unit_if.sv
// Instruction-fetch bus between the fetch unit and a combinational instruction ROM.
// The ROM returns data in the same cycle that addr is presented.
interface i_fetch_inst;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;

    modport master (output en, output addr, input data);
    modport slave  (input en, input addr, output data);
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the fetch bus and fills the IF/ID register.
// Branches use delay-slot semantics, so a redirect costs no bubble. A branch that arrives
// while IF is stalled is parked in a pending slot and taken once the stall releases.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    i_fetch_inst.master       inst,
    input  logic              stall_if,
    input  logic              stall_id,
    input  logic              branch_flag,
    input  logic [31:0]       branch_target,
    input  logic              flush,
    input  logic [31:0]       flush_pc,
    output logic [31:0]       id_pc,
    output logic [31:0]       id_inst,
    output logic              id_valid,
    output logic              id_adel,
    output logic [31:0]       fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] pend_target_q;
    logic        pend_valid_q;
    logic        en_q;
    logic        misaligned;

    assign inst.en    = en_q;
    assign inst.addr  = pc_q;
    assign misaligned = (pc_q[1:0] != 2'b00);

    // Fetch enable: low while in reset, high from the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // PC and pending-branch next state; flush beats stall beats pending beats branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
        end else if (flush) begin
            pc_q         <= flush_pc;
            pend_valid_q <= 1'b0;
        end else if (!en_q) begin
            // First cycle out of reset: the word at RESET_PC has not been fetched yet.
            pc_q <= pc_q;
        end else if (stall_if) begin
            if (branch_flag) begin
                pend_target_q <= branch_target;
                pend_valid_q  <= 1'b1;
            end
        end else if (pend_valid_q) begin
            pc_q         <= pend_target_q;
            pend_valid_q <= 1'b0;
        end else if (branch_flag) begin
            pc_q <= branch_target;
        end else begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // IF/ID pipeline register and count of valid instructions delivered to ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc       <= 32'h0;
            id_inst     <= NOP_INST;
            id_valid    <= 1'b0;
            id_adel     <= 1'b0;
            fetch_count <= 32'h0;
        end else if (flush || !en_q || (stall_if && !stall_id)) begin
            id_pc    <= 32'h0;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
        end else if (!stall_id) begin
            // A misaligned PC becomes an address-error entry carrying the bad address.
            id_pc    <= pc_q;
            id_inst  <= misaligned ? NOP_INST : inst.data;
            id_valid <= !misaligned;
            id_adel  <= misaligned;
            if (!misaligned) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios with constant expectations, then a
// randomized run compared cycle by cycle against a behavioural model of the stage.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_if = 1'b0;
    logic        stall_id = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // ROM contents: a scrambled function of the address so every word is distinct.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    i_fetch_inst ifc ();
    assign ifc.data = rom_word(ifc.addr);

    inst_fetch_unit #(
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst          (ifc),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .branch_flag   (branch_flag),
        .branch_target (branch_target),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_valid      (id_valid),
        .id_adel       (id_adel),
        .fetch_count   (fetch_count)
    );

    // Behavioural model: where the stage is fetching, what ID holds, and the parked branch.
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_parked;
    logic [31:0] m_parked_to;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;
    logic        m_id_adel;
    logic [31:0] m_count;

    task automatic model_edge(input bit r, input bit fl, input logic [31:0] fpc,
                              input bit sif, input bit sid, input bit br,
                              input logic [31:0] tgt);
        logic [31:0] cur;
        bit          bad;
        bit          deliver;
        bit          empty;
        cur = m_pc;
        bad = (cur % 4) != 0;
        if (r) begin
            m_pc = RESET_PC; m_started = 0; m_parked = 0;
            m_id_pc = 0; m_id_inst = NOP_INST; m_id_valid = 0; m_id_adel = 0; m_count = 0;
            return;
        end
        empty   = fl || !m_started || (sif && !sid);
        deliver = !empty && !sid;
        if (empty) begin
            m_id_pc = 0; m_id_inst = NOP_INST; m_id_valid = 0; m_id_adel = 0;
        end else if (deliver) begin
            m_id_pc    = cur;
            m_id_inst  = bad ? NOP_INST : rom_word(cur);
            m_id_valid = !bad;
            m_id_adel  = bad;
            m_count    = m_count + (bad ? 0 : 1);
        end
        // Where the next fetch comes from.
        if (fl) begin
            m_pc = fpc; m_parked = 0;
        end else if (!m_started) begin
            m_pc = cur;
        end else if (sif) begin
            if (br) begin m_parked = 1; m_parked_to = tgt; end
        end else if (m_parked) begin
            m_pc = m_parked_to; m_parked = 0;
        end else begin
            m_pc = br ? tgt : cur + 4;
        end
        m_started = 1;
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit fl, input logic [31:0] fpc, input bit sif, input bit sid,
                        input bit br, input logic [31:0] tgt);
        flush = fl; flush_pc = fpc; stall_if = sif; stall_id = sid;
        branch_flag = br; branch_target = tgt;
        model_edge(rst, fl, fpc, sif, sid, br, tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        idle();
        n_cmp++;
        if ({ifc.en, ifc.addr, id_pc, id_inst, id_valid, id_adel, fetch_count} !==
            {1'b0, RESET_PC, 32'h0, NOP_INST, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state en=%b addr=%h id_pc=%h id_inst=%h v=%b adel=%b cnt=%0d",
                     ifc.en, ifc.addr, id_pc, id_inst, id_valid, id_adel, fetch_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        idle();
        n_cmp++;
        if ({ifc.en, ifc.addr, id_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL first_enable en=%b addr=%h id_valid=%b, want 1 0 0",
                     ifc.en, ifc.addr, id_valid);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            idle();
            n_cmp++;
            if ({id_pc, id_inst, id_valid, id_adel} !== {a, rom_word(a), 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL seq_fetch id_pc=%h id_inst=%h v=%b, want %h %h 1",
                         id_pc, id_inst, id_valid, a, rom_word(a));
            end
        end
        n_cmp++;
        if (fetch_count !== 32'd4) begin
            n_fail++;
            $display("FAIL seq_count fetch_count=%0d, want 4", fetch_count);
        end
    endtask

    // pc=0x10: branch during first of two IF stalls is parked and taken after release.
    task automatic test_stall_branch();
        step(0, 32'h0, 1, 0, 1, 32'h200);
        n_cmp++;
        if ({id_valid, ifc.addr} !== {1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL stall_bubble1 id_valid=%b addr=%h, want 0 00000010", id_valid, ifc.addr);
        end
        step(0, 32'h0, 1, 0, 0, 32'h0);
        n_cmp++;
        if ({id_valid, ifc.addr} !== {1'b0, 32'h10}) begin
            n_fail++;
            $display("FAIL stall_bubble2 id_valid=%b addr=%h, want 0 00000010", id_valid, ifc.addr);
        end
        idle();
        n_cmp++;
        if ({id_pc, id_valid, ifc.addr} !== {32'h10, 1'b1, 32'h200}) begin
            n_fail++;
            $display("FAIL stall_release id_pc=%h v=%b addr=%h, want 10 1 200",
                     id_pc, id_valid, ifc.addr);
        end
        idle();
        n_cmp++;
        if ({id_pc, ifc.addr} !== {32'h200, 32'h204}) begin
            n_fail++;
            $display("FAIL pend_taken id_pc=%h addr=%h, want 200 204 (pending cleared)",
                     id_pc, ifc.addr);
        end
    endtask

    // Branch while fetching 0x208: delay slot delivered, then target with no bubble.
    task automatic test_branch();
        idle();
        step(0, 32'h0, 0, 0, 1, 32'h100);
        n_cmp++;
        if ({id_pc, id_valid, ifc.addr} !== {32'h208, 1'b1, 32'h100}) begin
            n_fail++;
            $display("FAIL delay_slot id_pc=%h v=%b addr=%h, want 208 1 100",
                     id_pc, id_valid, ifc.addr);
        end
        idle();
        n_cmp++;
        if ({id_pc, id_inst, id_valid} !== {32'h100, rom_word(32'h100), 1'b1}) begin
            n_fail++;
            $display("FAIL branch_target id_pc=%h id_inst=%h v=%b, want 100 %h 1",
                     id_pc, id_inst, id_valid, rom_word(32'h100));
        end
    endtask

    task automatic test_hold_flush();
        logic [31:0] cnt;
        idle();
        cnt = fetch_count;
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 1, 1, 0, 32'h0);
            n_cmp++;
            if ({id_pc, id_inst, id_valid, fetch_count, ifc.addr} !==
                {32'h104, rom_word(32'h104), 1'b1, cnt, 32'h108}) begin
                n_fail++;
                $display("FAIL hold id_pc=%h v=%b cnt=%0d addr=%h, want 104 1 %0d 108",
                         id_pc, id_valid, fetch_count, ifc.addr, cnt);
            end
        end
        step(1, 32'h180, 1, 1, 1, 32'h400);
        n_cmp++;
        if ({id_valid, id_pc, ifc.addr} !== {1'b0, 32'h0, 32'h180}) begin
            n_fail++;
            $display("FAIL flush_bubble v=%b id_pc=%h addr=%h, want 0 0 180",
                     id_valid, id_pc, ifc.addr);
        end
        idle();
        n_cmp++;
        if ({id_pc, id_valid} !== {32'h180, 1'b1}) begin
            n_fail++;
            $display("FAIL flush_target id_pc=%h v=%b, want 180 1", id_pc, id_valid);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] cnt;
        step(0, 32'h0, 0, 0, 1, 32'h102);
        cnt = fetch_count;
        idle();
        n_cmp++;
        if ({id_adel, id_pc, id_inst, id_valid, fetch_count} !==
            {1'b1, 32'h102, NOP_INST, 1'b0, cnt}) begin
            n_fail++;
            $display("FAIL adel adel=%b id_pc=%h inst=%h v=%b cnt=%0d, want 1 102 %h 0 %0d",
                     id_adel, id_pc, id_inst, id_valid, fetch_count, NOP_INST, cnt);
        end
        step(1, 32'h0, 0, 0, 0, 32'h0);
        n_cmp++;
        if ({id_adel, id_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL adel_flush adel=%b v=%b, want 0 0", id_adel, id_valid);
        end
    endtask

    task automatic test_wrap();
        step(1, 32'hFFFF_FFF8, 0, 0, 0, 32'h0);
        idle();
        n_cmp++;
        if (ifc.addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_pre addr=%h, want fffffffc", ifc.addr);
        end
        idle();
        n_cmp++;
        if ({id_pc, ifc.addr} !== {32'hFFFF_FFFC, 32'h0}) begin
            n_fail++;
            $display("FAIL wrap id_pc=%h addr=%h, want fffffffc 0", id_pc, ifc.addr);
        end
    endtask

    task automatic test_reset_pending();
        step(0, 32'h0, 1, 0, 1, 32'h300);
        rst = 1'b1;
        idle();
        n_cmp++;
        if ({ifc.en, ifc.addr, id_valid, fetch_count} !== {1'b0, RESET_PC, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_pend en=%b addr=%h v=%b cnt=%0d, want 0 %h 0 0",
                     ifc.en, ifc.addr, id_valid, fetch_count, RESET_PC);
        end
        rst = 1'b0;
        idle();
        idle();
        idle();
        n_cmp++;
        if ({id_pc, ifc.addr} !== {RESET_PC + 32'h4, RESET_PC + 32'h8}) begin
            n_fail++;
            $display("FAIL reset_pend_gone id_pc=%h addr=%h, parked branch survived reset",
                     id_pc, ifc.addr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit          fl, sif, sid, br;
            logic [31:0] fpc, tgt;
            rst = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 99) < 4);
            sif = ($urandom_range(0, 99) < 20);
            sid = sif && ($urandom_range(0, 1) == 1);
            br  = ($urandom_range(0, 99) < 15);
            fpc = {$urandom_range(0, 255), 2'b00} << 2;
            tgt = {$urandom_range(0, 1023), 2'b00};
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) tgt = 32'hFFFF_FFF0;
            step(fl, fpc, sif, sid, br, tgt);
            n_cmp++;
            if ({ifc.en, ifc.addr, id_pc, id_inst, id_valid, id_adel, fetch_count} !==
                {m_started, m_pc, m_id_pc, m_id_inst, m_id_valid, m_id_adel, m_count}) begin
                n_fail++;
                $display("FAIL random[%0d] got en=%b addr=%h pc=%h inst=%h v=%b adel=%b cnt=%0d want en=%b addr=%h pc=%h inst=%h v=%b adel=%b cnt=%0d",
                         i, ifc.en, ifc.addr, id_pc, id_inst, id_valid, id_adel, fetch_count,
                         m_started, m_pc, m_id_pc, m_id_inst, m_id_valid, m_id_adel, m_count);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_branch();
        test_branch();
        test_hold_flush();
        test_misaligned();
        test_wrap();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Master end of the `i_fetch_inst` instruction-fetch interface: owns the PC and drives `en`/`addr`, then captures the returned `data` into the IF/ID pipeline register.
- Handles sequential fetch, branch redirect (delay-slot semantics: the already-fetched instruction after a branch executes), pipeline stall/bubble, exception flush and misaligned-target detection.
- Sits between pipeline control/ID stage and the combinational instruction ROM (read data is valid in the same cycle as `addr`).

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word injected on bubbles, flushes and address errors.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inst  modport `i_fetch_inst.master`  -  fetch interface bundle:
  - `en` out 1.
  - `addr` out 32.
  - `data` in 32.
- stall_if  input  1  hold PC and pending-branch state this cycle.
- stall_id  input  1  ID stage stalled; hold IF/ID register.
- branch_flag  input  1  ID resolved a taken branch/jump this cycle.
- branch_target  input  32  target address accompanying branch_flag.
- flush  input  1  exception/eret flush; highest priority after rst.
- flush_pc  input  32  redirect address for flush.
- id_pc  output  32  PC of the instruction in IF/ID.
- id_inst  output  32  instruction in IF/ID.
- id_valid  output  1  IF/ID holds a real instruction.
- id_adel  output  1  IF/ID entry is an instruction-fetch address error (id_pc = bad address).
- fetch_count  output  32  number of instructions loaded into IF/ID with id_valid=1.

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC; pend_valid=0; en register=0.
  - id_pc=0, id_inst=NOP_INST, id_valid=0, id_adel=0, fetch_count=0.
  - Reset mid-stall or with a pending branch discards all state.
- `en` is a register: 0 during the reset cycle(s), 1 from the first edge after rst deasserts.
- `addr` = pc (combinational from the PC register); addr is never driven while en=0 from stale state (addr=pc regardless, ROM ignores it).
- PC next-state priority (evaluated every edge, rst=0):
  1. flush: pc=flush_pc; pend_valid=0.
  2. stall_if: pc holds; if branch_flag, latch pend_target=branch_target, pend_valid=1 (a later branch_flag while pend_valid overwrites).
  3. pend_valid: pc=pend_target; pend_valid=0 (a simultaneous branch_flag is ignored; ID is required not to issue one then).
  4. branch_flag: pc=branch_target.
  5. otherwise: pc=pc+4 (32-bit wrap: 32'hFFFF_FFFC -> 32'h0).
- Fetch validity: the word at addr is usable only when en=1.
  - Misaligned (pc[1:0]!=0): fetch is an address error; data is ignored, loaded as NOP_INST with id_adel=1, id_valid=0, id_pc=pc; PC then proceeds per the priority rules.
- IF/ID register update priority:
  1. flush or en=0: bubble (id_inst=NOP_INST, id_valid=0, id_adel=0, id_pc=0).
  2. stall_if=1 and stall_id=0: bubble.
  3. stall_id=1: hold all IF/ID outputs.
  4. otherwise load: id_pc=pc, id_inst=inst.data (or NOP per misalignment), id_valid=!misaligned, id_adel=misaligned.
- Latency: instruction at PC appears on id_* one edge after pc holds that value with no stall.
- Branch redirect:
  - The branch arrives while its delay-slot instruction is being fetched.
  - The delay slot loads normally and the target is fetched the following cycle: one-cycle redirect, no bubble.
- fetch_count: +1 on each load with id_valid=1; wraps at 2^32; reset only by rst.
- Simultaneous events:
  - flush with stall_if/stall_id/branch_flag: flush wins for both PC and IF/ID.
  - stall_id=1 with stall_if=0 is illegal (control never produces it); behaviour in that case: PC advances, IF/ID holds. Verification must not rely on this.

Test Plan:
- Reset then free-run, ROM words W0..W3 at 0x0..0xC -> en=1 one cycle after rst low; id_pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching words, id_valid=1; fetch_count=4.
- branch_flag=1, target=0x100 while pc=0x8 -> id gets 0x8 (delay slot), next id_pc=0x100; no bubble.
- stall_if=1, stall_id=0 for 2 cycles at pc=0x10 with branch_flag=1, target=0x200 in the first stall cycle -> 2 bubbles (id_valid=0), pc holds 0x10; after release pc=0x200 fetched next; pend_valid cleared.
- stall_if=stall_id=1 for 3 cycles -> id_* frozen, fetch_count unchanged; flush=1, flush_pc=0x180 during the stall -> bubble, next id_pc=0x180.
- branch_target=0x102 -> id_adel=1, id_pc=0x102, id_inst=NOP_INST, id_valid=0; fetch_count not incremented.
- pc=0xFFFF_FFFC sequential -> next addr=0x0; rst asserted with pend_valid=1 -> pc=RESET_PC, pend_valid=0, id_valid=0.
